// File: rtl/jpeg_bit_window.sv
// Byte-to-bit window: loads one byte per cycle into a 128-bit MSB-first buffer and removes 0xFF00 stuffing.
// Latency 1 cycle byte-to-window; in_ready drops above 120 valid bits or after EOF, and the source holds the byte.
module jpeg_bit_window #(
    parameter int BUF_W = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        unstuff_en,
    input  logic        shift_en,
    input  logic [6:0]  shift_len,
    input  logic        align_en,
    output logic [63:0] bit_out,
    output logic        bit_avali,
    output logic [7:0]  bit_count,
    output logic        marker_hit,
    output logic        drained
);

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [BUF_W-1:0] byte_ext;
    logic [7:0]       count_q, count_d;
    logic             ff_prev_q, ff_prev_d;
    logic             eof_q, eof_d;
    logic             marker_q, marker_d;
    logic             take, drop, load;
    logic [7:0]       len_sat, s;

    always_comb begin
        in_ready  = !rst && !eof_q && (count_q <= 8'd120);
        bit_avali = (count_q >= 8'd64) || (eof_q && (count_q != 8'd0));
        take      = in_valid && in_ready;
        drop      = take && unstuff_en && ff_prev_q && (in_byte == 8'h00);
        load      = take && !drop;

        len_sat = ({1'b0, shift_len} > 8'd64) ? 8'd64 : {1'b0, shift_len};
        s       = 8'd0;
        if (shift_en && bit_avali) begin
            s = (len_sat < count_q) ? len_sat : count_q;
        end else if (align_en) begin
            s = {5'b0, count_q[2:0]};
        end

        // New byte lands directly below the bits that survive this cycle's consume.
        byte_ext = {in_byte, {(BUF_W-8){1'b0}}};
        buf_d    = buf_q << s;
        if (load) begin
            buf_d = buf_d | (byte_ext >> (count_q - s));
        end
        count_d = count_q - s + (load ? 8'd8 : 8'd0);

        ff_prev_d = ff_prev_q;
        marker_d  = 1'b0;
        if (take) begin
            if (unstuff_en) begin
                marker_d  = ff_prev_q && (in_byte != 8'h00) && (in_byte != 8'hFF);
                ff_prev_d = (in_byte == 8'hFF);
            end else begin
                ff_prev_d = 1'b0;
            end
        end
        eof_d = eof_q || (take && in_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q     <= '0;
            count_q   <= 8'd0;
            ff_prev_q <= 1'b0;
            eof_q     <= 1'b0;
            marker_q  <= 1'b0;
        end else begin
            buf_q     <= buf_d;
            count_q   <= count_d;
            ff_prev_q <= ff_prev_d;
            eof_q     <= eof_d;
            marker_q  <= marker_d;
        end
    end

    assign bit_out    = buf_q[BUF_W-1 -: 64];
    assign bit_count  = count_q;
    assign marker_hit = marker_q;
    assign drained    = eof_q && (count_q == 8'd0);

endmodule

// File: tb/tb_jpeg_bit_window.sv
// Bench for jpeg_bit_window: bit-queue reference model checked every cycle plus directed literal checks.
module tb_jpeg_bit_window;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_last, in_ready, unstuff_en, shift_en, align_en;
    logic        bit_avali, marker_hit, drained;
    logic [7:0]  in_byte, bit_count;
    logic [6:0]  shift_len;
    logic [63:0] bit_out;

    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;
    logic acc;
    logic [7:0] nb;

    always #5 clk = ~clk;

    jpeg_bit_window #(.BUF_W(128)) dut (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .unstuff_en(unstuff_en), .shift_en(shift_en), .shift_len(shift_len),
        .align_en(align_en), .bit_out(bit_out), .bit_avali(bit_avali), .bit_count(bit_count),
        .marker_hit(marker_hit), .drained(drained)
    );

    // Reference: the buffer is a plain queue of bits, oldest first.
    bit mq[$];
    bit m_ff, m_eof, m_marker;

    function automatic bit m_avail();
        return (mq.size() >= 64) || (m_eof && mq.size() > 0);
    endfunction

    function automatic bit m_ready();
        return !rst && !m_eof && (mq.size() <= 120);
    endfunction

    function automatic logic [63:0] m_window();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++)
            if (i < mq.size()) r[63-i] = mq[i];
        return r;
    endfunction

    always @(posedge clk) begin
        int s;
        bit take, drop;
        if (rst) begin
            mq.delete();
            m_ff = 0; m_eof = 0; m_marker = 0;
        end else begin
            take = in_valid && m_ready();
            s = 0;
            if (shift_en && m_avail()) begin
                s = int'(shift_len);
                if (s > 64) s = 64;
                if (s > mq.size()) s = mq.size();
            end else if (align_en) begin
                s = mq.size() % 8;
            end
            repeat (s) void'(mq.pop_front());
            m_marker = 0;
            drop = 0;
            if (take) begin
                if (unstuff_en) begin
                    drop     = m_ff && (in_byte == 8'h00);
                    m_marker = m_ff && (in_byte != 8'h00) && (in_byte != 8'hFF);
                    m_ff     = (in_byte == 8'hFF);
                end else begin
                    m_ff = 0;
                end
                if (!drop)
                    for (int i = 7; i >= 0; i--) mq.push_back(in_byte[i]);
                if (in_last) m_eof = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_bit_out",    bit_out,    m_window());
            chk("cyc_bit_count",  {56'b0, bit_count}, 64'(mq.size()));
            chk("cyc_bit_avali",  {63'b0, bit_avali}, {63'b0, m_avail()});
            chk("cyc_in_ready",   {63'b0, in_ready},  {63'b0, m_ready()});
            chk("cyc_marker_hit", {63'b0, marker_hit}, {63'b0, m_marker});
            chk("cyc_drained",    {63'b0, drained},   {63'b0, (m_eof && mq.size() == 0)});
        end
    end

    task automatic cyc();
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b, input logic last);
        in_valid = 1'b1; in_byte = b; in_last = last;
        cyc();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; shift_en = 1'b0; align_en = 1'b0; in_last = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0; unstuff_en = 1'b0;
        shift_en = 1'b0; shift_len = 7'd0; align_en = 1'b0; acc = 1'b0;
        cyc();
        cmp_en = 1'b1;
        cyc();
        chk("rst_bit_out",   bit_out, 64'h0);
        chk("rst_bit_count", {56'b0, bit_count}, 64'd0);
        chk("rst_in_ready",  {63'b0, in_ready}, 64'd0);
        chk("rst_avali",     {63'b0, bit_avali}, 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {63'b0, in_ready}, 64'd1);

        // Fill 0x01..0x08 from empty.
        for (int i = 1; i <= 8; i++) begin
            push(8'(i), 1'b0);
            if (i == 7) chk("avali_before_8th", {63'b0, bit_avali}, 64'd0);
        end
        chk("fill_bit_out",   bit_out, 64'h0102030405060708);
        chk("fill_count",     {56'b0, bit_count}, 64'd64);
        chk("fill_avali",     {63'b0, bit_avali}, 64'd1);
        chk("model_fill_win", m_window(), 64'h0102030405060708);

        // Load 0x09 and consume 4 bits on the same edge, then byte-align.
        in_valid = 1'b1; in_byte = 8'h09; shift_en = 1'b1; shift_len = 7'd4;
        cyc();
        in_valid = 1'b0; shift_en = 1'b0;
        chk("shift4_bit_out", bit_out, 64'h1020304050607080);
        chk("shift4_count",   {56'b0, bit_count}, 64'd68);
        align_en = 1'b1;
        cyc();
        align_en = 1'b0;
        chk("align_bit_out", bit_out, 64'h0203040506070809);
        chk("align_count",   {56'b0, bit_count}, 64'd64);
        chk("model_align_cnt", 64'(mq.size()), 64'd64);

        // Stuffing removal on and off.
        do_reset();
        unstuff_en = 1'b1;
        push(8'hAB, 1'b0); push(8'hFF, 1'b0); push(8'h00, 1'b0); push(8'hCD, 1'b0);
        chk("unstuff_count",   {56'b0, bit_count}, 64'd24);
        chk("unstuff_bit_out", bit_out, 64'hABFFCD0000000000);
        chk("unstuff_marker",  {63'b0, marker_hit}, 64'd0);
        do_reset();
        unstuff_en = 1'b0;
        push(8'hAB, 1'b0); push(8'hFF, 1'b0); push(8'h00, 1'b0); push(8'hCD, 1'b0);
        chk("raw_count",   {56'b0, bit_count}, 64'd32);
        chk("raw_bit_out", bit_out, 64'hABFF00CD00000000);
        chk("model_raw_win", m_window(), 64'hABFF00CD00000000);

        // Marker at end of file, then drain.
        do_reset();
        unstuff_en = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(8'h11 + i), 1'b0);
        push(8'hFF, 1'b0);
        push(8'hD9, 1'b1);
        chk("eoi_marker",   {63'b0, marker_hit}, 64'd1);
        chk("eoi_count",    {56'b0, bit_count}, 64'd80);
        chk("eoi_in_ready", {63'b0, in_ready}, 64'd0);
        chk("eoi_bit_out",  bit_out, 64'h1112131415161718);
        cyc();
        chk("marker_one_cycle", {63'b0, marker_hit}, 64'd0);
        in_valid = 1'b1; in_byte = 8'h55; shift_en = 1'b1; shift_len = 7'd64;
        cyc();
        chk("tail_count",   {56'b0, bit_count}, 64'd16);
        chk("tail_bit_out", bit_out, 64'hFFD9000000000000);
        chk("tail_avali",   {63'b0, bit_avali}, 64'd1);
        chk("tail_drained", {63'b0, drained}, 64'd0);
        cyc();
        in_valid = 1'b0; shift_en = 1'b0;
        chk("drain_count",   {56'b0, bit_count}, 64'd0);
        chk("drain_avali",   {63'b0, bit_avali}, 64'd0);
        chk("drain_drained", {63'b0, drained}, 64'd1);

        // Backpressure: hold valid until full, saturated shift, refill.
        do_reset();
        unstuff_en = 1'b0;
        nb = 8'h20;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_byte = nb; cyc();
            if (acc) nb = nb + 8'd1;
        end
        chk("full_count",    {56'b0, bit_count}, 64'd128);
        chk("full_in_ready", {63'b0, in_ready}, 64'd0);
        shift_en = 1'b1; shift_len = 7'd100; in_byte = nb;
        cyc();
        shift_en = 1'b0;
        chk("sat_shift_count", {56'b0, bit_count}, 64'd64);
        for (int c = 0; c < 10; c++) begin
            in_byte = nb; cyc();
            if (acc) nb = nb + 8'd1;
        end
        in_valid = 1'b0;
        chk("refill_count",   {56'b0, bit_count}, 64'd128);
        chk("refill_bit_out", bit_out, 64'h28292A2B2C2D2E2F);
        shift_en = 1'b1; shift_len = 7'd64;
        cyc();
        shift_en = 1'b0;
        chk("refill_next_win", bit_out, 64'h3031323334353637);

        // Reset mid-operation with count 100 and a pending 0xFF.
        do_reset();
        unstuff_en = 1'b1;
        for (int i = 0; i < 12; i++) push(8'(8'h40 + i), 1'b0);
        push(8'hFF, 1'b0);
        shift_en = 1'b1; shift_len = 7'd4;
        cyc();
        shift_en = 1'b0;
        chk("pre_rst_count", {56'b0, bit_count}, 64'd100);
        rst = 1'b1; in_valid = 1'b1; in_byte = 8'h77;
        cyc();
        chk("mid_rst_count",   {56'b0, bit_count}, 64'd0);
        chk("mid_rst_bit_out", bit_out, 64'h0);
        chk("mid_rst_ready",   {63'b0, in_ready}, 64'd0);
        chk("mid_rst_drained", {63'b0, drained}, 64'd0);
        rst = 1'b0; in_byte = 8'h00;
        cyc();
        in_valid = 1'b0;
        chk("post_rst_zero_loaded", {56'b0, bit_count}, 64'd8);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
